modbus_rtu_master: RTL and testbench



---
 rtl/modbus_rtu_master.sv | 214 +++++++++++++++++++++
 tb/tb_modbus_rtu_master.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/modbus_rtu_master.sv
// Modbus RTU initiator: sends function 03/06 requests over a UART byte stream,
// drives the RS485 direction pin and parses the responder's reply.
module modbus_rtu_master #(
    parameter int MAX_REGS    = 16,
    parameter int TIMEOUT_CYC = 10_000_000,
    parameter int GAP_CYC     = 33_420
) (
    input  logic        clk_100m,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_func,
    input  logic [7:0]  cmd_slave,
    input  logic [15:0] cmd_reg,
    input  logic [4:0]  cmd_cnt,
    input  logic [15:0] cmd_wdata,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic        tx_idle,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        con,
    output logic [15:0] rd_word,
    output logic        rd_word_valid,
    output logic [3:0]  rd_word_idx,
    output logic        done,
    output logic [2:0]  err,
    output logic [7:0]  exc_code
);
    localparam int TW = $clog2((TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC) + 1;

    typedef enum logic [3:0] {
        S_IDLE, S_CHECK_CMD, S_TX, S_DRAIN, S_RX_WAIT, S_RX, S_CHECK, S_EMIT, S_DONE
    } state_t;

    state_t        r_state, w_nxt;
    logic [2:0]    w_err;
    logic          r_en;
    logic [2:0]    r_err;
    logic [7:0]    r_exc_code;
    logic          r_func;
    logic [7:0]    r_slave;
    logic [15:0]   r_reg, r_wdata;
    logic [4:0]    r_cnt;
    logic [2:0]    r_idx;
    logic [15:0]   r_crc, r_rcrc;
    logic [5:0]    r_rxcnt, r_explen;
    logic [TW-1:0] r_tmr;
    logic          r_exc, r_fmt;
    logic [3:0]    r_widx;
    logic [15:0]   r_buf [0:MAX_REGS-1];
    logic [7:0]    w_fcode, w_txbyte;
    logic          w_rx_take, w_last, w_buf_wr;
    logic [3:0]    w_bidx;

    function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] x;
        x = c ^ {8'h00, b};
        for (int i = 0; i < 8; i++)
            x = x[0] ? ((x >> 1) ^ 16'hA001) : (x >> 1);
        return x;
    endfunction

    assign w_fcode   = r_func ? 8'h06 : 8'h03;
    assign w_rx_take = rx_valid && ((r_state == S_RX_WAIT) || (r_state == S_RX));
    assign w_last    = (r_rxcnt + 6'd1) == r_explen;
    assign w_buf_wr  = !r_func && !r_exc && (r_rxcnt >= 6'd3) && (r_rxcnt < (6'd3 + {r_cnt, 1'b0}));
    assign w_bidx    = 4'((r_rxcnt - 6'd3) >> 1);

    always_comb begin
        w_txbyte = 8'h00;
        case (r_idx)
            3'd0: w_txbyte = r_slave;
            3'd1: w_txbyte = w_fcode;
            3'd2: w_txbyte = r_reg[15:8];
            3'd3: w_txbyte = r_reg[7:0];
            3'd4: w_txbyte = r_func ? r_wdata[15:8] : 8'h00;
            3'd5: w_txbyte = r_func ? r_wdata[7:0] : {3'b000, r_cnt};
            3'd6: w_txbyte = r_crc[7:0];
            default: w_txbyte = r_crc[15:8];
        endcase
    end

    assign cmd_ready     = r_en && (r_state == S_IDLE);
    assign tx_valid      = (r_state == S_TX);
    assign tx_data       = tx_valid ? w_txbyte : 8'h00;
    assign con           = (r_state == S_TX) || (r_state == S_DRAIN);
    assign rd_word_valid = (r_state == S_EMIT);
    assign rd_word       = rd_word_valid ? r_buf[r_widx] : 16'h0000;
    assign rd_word_idx   = rd_word_valid ? r_widx : 4'd0;
    assign done          = (r_state == S_DONE);
    assign err           = done ? r_err : 3'd0;
    assign exc_code      = r_exc_code;

    always_ff @(posedge clk_100m) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_nxt;
    end

    always_comb begin
        w_nxt = r_state;
        w_err = 3'd0;
        case (r_state)
            S_IDLE:      if (cmd_valid && cmd_ready) w_nxt = S_CHECK_CMD;
            S_CHECK_CMD: begin
                if (!r_func && ((r_cnt == 5'd0) || ({27'd0, r_cnt} > 32'(MAX_REGS)))) begin
                    w_nxt = S_DONE;
                    w_err = 3'd5;
                end else begin
                    w_nxt = S_TX;
                end
            end
            S_TX:        if (tx_ready && (r_idx == 3'd7)) w_nxt = S_DRAIN;
            // Broadcast writes get no reply, so finish as soon as the line is released.
            S_DRAIN:     if (tx_idle) w_nxt = (r_func && (r_slave == 8'h00)) ? S_DONE : S_RX_WAIT;
            S_RX_WAIT: begin
                if (rx_valid) w_nxt = S_RX;
                else if (r_tmr == TW'(TIMEOUT_CYC - 1)) begin
                    w_nxt = S_DONE;
                    w_err = 3'd1;
                end
            end
            S_RX: begin
                if (rx_valid) begin
                    if (w_last) w_nxt = S_CHECK;
                end else if (r_tmr == TW'(GAP_CYC - 1)) begin
                    w_nxt = S_DONE;
                    w_err = 3'd4;
                end
            end
            S_CHECK: begin
                w_nxt = S_DONE;
                if (r_rcrc != 16'h0000) w_err = 3'd2;
                else if (r_exc)         w_err = 3'd3;
                else if (r_fmt)         w_err = 3'd4;
                else if (!r_func)       w_nxt = S_EMIT;
            end
            S_EMIT:      if ({1'b0, r_widx} == (r_cnt - 5'd1)) w_nxt = S_DONE;
            S_DONE:      w_nxt = S_IDLE;
            default:     w_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_100m) begin
        if (!rst_n) begin
            r_en       <= 1'b0;
            r_err      <= 3'd0;
            r_exc_code <= 8'h00;
        end else begin
            r_en <= 1'b1;
            if (w_nxt == S_DONE) r_err <= w_err;
            if (cmd_valid && cmd_ready) r_exc_code <= 8'h00;
            else if (w_rx_take && (r_rxcnt == 6'd2) && r_exc) r_exc_code <= rx_data;
        end
    end

    // Running CRC over the whole reply, including its CRC bytes, ends at zero when intact.
    always_ff @(posedge clk_100m) begin
        case (r_state)
            S_IDLE: if (cmd_valid && cmd_ready) begin
                r_func  <= cmd_func;
                r_slave <= cmd_slave;
                r_reg   <= cmd_reg;
                r_cnt   <= cmd_cnt;
                r_wdata <= cmd_wdata;
                r_idx   <= 3'd0;
                r_crc   <= 16'hFFFF;
            end
            S_CHECK_CMD: begin
                r_explen <= r_func ? 6'd8 : (6'd5 + {r_cnt, 1'b0});
                r_rcrc   <= 16'hFFFF;
                r_rxcnt  <= 6'd0;
                r_exc    <= 1'b0;
                r_fmt    <= 1'b0;
                r_widx   <= 4'd0;
            end
            S_TX: if (tx_ready) begin
                r_idx <= r_idx + 3'd1;
                if (r_idx < 3'd6) r_crc <= crc_upd(r_crc, w_txbyte);
            end
            S_DRAIN: r_tmr <= '0;
            S_RX_WAIT, S_RX: begin
                if (rx_valid) begin
                    r_tmr   <= '0;
                    r_rxcnt <= r_rxcnt + 6'd1;
                    r_rcrc  <= crc_upd(r_rcrc, rx_data);
                    case (r_rxcnt)
                        6'd0: if (rx_data != r_slave) r_fmt <= 1'b1;
                        6'd1: begin
                            if (rx_data == (w_fcode | 8'h80)) begin
                                r_exc    <= 1'b1;
                                r_explen <= 6'd5;
                            end else if (rx_data != w_fcode) r_fmt <= 1'b1;
                        end
                        6'd2: if (!r_exc && (rx_data != (r_func ? r_reg[15:8] : {2'b00, r_cnt, 1'b0}))) r_fmt <= 1'b1;
                        6'd3: if (r_func && !r_exc && (rx_data != r_reg[7:0])) r_fmt <= 1'b1;
                        6'd4: if (r_func && !r_exc && (rx_data != r_wdata[15:8])) r_fmt <= 1'b1;
                        6'd5: if (r_func && !r_exc && (rx_data != r_wdata[7:0])) r_fmt <= 1'b1;
                        default: ;
                    endcase
                    if (w_buf_wr) begin
                        if (r_rxcnt[0]) r_buf[w_bidx][15:8] <= rx_data;
                        else            r_buf[w_bidx][7:0]  <= rx_data;
                    end
                end else begin
                    r_tmr <= r_tmr + 1'b1;
                end
            end
            S_EMIT: r_widx <= r_widx + 4'd1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_modbus_rtu_master.sv
// Directed bench for modbus_rtu_master: request framing, reply parsing,
// error codes, timeout/gap timing, broadcast and mid-frame reset.
module tb_modbus_rtu_master;
    localparam int TMO = 1000;
    localparam int GAP = 200;
    typedef logic [7:0] bq_t [$];

    logic        clk_100m = 1'b0;
    logic        rst_n, cmd_valid, cmd_ready, cmd_func;
    logic [7:0]  cmd_slave;
    logic [15:0] cmd_reg, cmd_wdata;
    logic [4:0]  cmd_cnt;
    logic [7:0]  tx_data, rx_data, exc_code;
    logic        tx_valid, tx_ready, tx_idle, rx_valid, con, rd_word_valid, done;
    logic [15:0] rd_word;
    logic [3:0]  rd_word_idx;
    logic [2:0]  err;
    logic [2:0]  busy;

    always #5 clk_100m = ~clk_100m;

    modbus_rtu_master #(.MAX_REGS(16), .TIMEOUT_CYC(TMO), .GAP_CYC(GAP)) dut (
        .clk_100m(clk_100m), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_func(cmd_func),
        .cmd_slave(cmd_slave), .cmd_reg(cmd_reg), .cmd_cnt(cmd_cnt), .cmd_wdata(cmd_wdata),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_idle(tx_idle),
        .rx_data(rx_data), .rx_valid(rx_valid), .con(con),
        .rd_word(rd_word), .rd_word_valid(rd_word_valid), .rd_word_idx(rd_word_idx),
        .done(done), .err(err), .exc_code(exc_code)
    );

    // UART transmitter model: each accepted byte keeps the shifter busy for 4 cycles.
    assign tx_ready = (busy == 3'd0);
    assign tx_idle  = (busy == 3'd0);
    always_ff @(posedge clk_100m) begin
        if (!rst_n)                    busy <= 3'd0;
        else if (tx_valid && tx_ready) busy <= 3'd4;
        else if (busy != 3'd0)         busy <= busy - 3'd1;
    end

    int nvec, nfail, cyc, ndone, ndone_base;
    int done_cyc, con_fall_cyc, last_rx_cyc, rd_first, rd_last;
    logic [2:0] last_err;
    logic [7:0] last_exc;
    bit con_seen, prev_con, prev_idle, fall_ok;
    bq_t txq;
    logic [15:0] rdq [$];
    logic [3:0]  rdiq [$];

    function automatic logic [15:0] mcrc(input bq_t f);
        logic [15:0] c = 16'hFFFF;
        logic fb;
        foreach (f[i])
            for (int j = 0; j < 8; j++) begin
                fb = c[0] ^ f[i][j];
                c  = c >> 1;
                if (fb) c = c ^ 16'hA001;
            end
        return c;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_100m);
        cyc++;
        if (tx_valid && tx_ready) txq.push_back(tx_data);
        if (rd_word_valid) begin
            if (rdq.size() == 0) rd_first = cyc;
            rd_last = cyc;
            rdq.push_back(rd_word);
            rdiq.push_back(rd_word_idx);
        end
        if (done) begin
            ndone++;
            last_err = err;
            last_exc = exc_code;
            done_cyc = cyc;
        end
        if (con) con_seen = 1'b1;
        if (prev_con && !con) begin
            con_fall_cyc = cyc;
            fall_ok      = prev_idle;
        end
        prev_con  = con;
        prev_idle = tx_idle;
    endtask

    task automatic issue(input logic f, input logic [7:0] s, input logic [15:0] r,
                         input logic [4:0] c, input logic [15:0] w);
        int n = 0;
        while (!cmd_ready && n < 50) begin tick(); n++; end
        chk("issue_ready", 32'(cmd_ready), 32'd1);
        txq.delete(); rdq.delete(); rdiq.delete();
        con_seen = 1'b0; fall_ok = 1'b0; con_fall_cyc = -1; ndone_base = ndone;
        cmd_valid = 1'b1; cmd_func = f; cmd_slave = s; cmd_reg = r; cmd_cnt = c; cmd_wdata = w;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_con_fall(input string tag);
        int n = 0;
        while (con_fall_cyc < 0 && n < 500) begin tick(); n++; end
        chk({tag, "_con_fall"}, 32'(con_fall_cyc >= 0), 32'd1);
    endtask

    task automatic wait_done(input string tag, input int bound);
        int n = 0;
        while (ndone == ndone_base && n < bound) begin tick(); n++; end
        tick();
        chk({tag, "_done_cnt"}, 32'(ndone - ndone_base), 32'd1);
    endtask

    task automatic send_bytes(input bq_t f);
        foreach (f[i]) begin
            rx_data = f[i]; rx_valid = 1'b1;
            tick();
            last_rx_cyc = cyc;
            rx_valid = 1'b0; rx_data = 8'h00;
            tick();
        end
    endtask

    task automatic send_crc(input bq_t f, input logic [7:0] flip);
        logic [15:0] c = mcrc(f);
        f.push_back(c[7:0]);
        f.push_back(c[15:8] ^ flip);
        send_bytes(f);
    endtask

    task automatic chk_tx(input string tag, input bq_t e);
        chk({tag, "_len"}, 32'(txq.size()), 32'(e.size()));
        foreach (e[i])
            chk($sformatf("%s_b%0d", tag, i), (i < txq.size()) ? 32'(txq[i]) : 32'hDEAD, 32'(e[i]));
    endtask

    initial begin
        bq_t f;
        logic [15:0] c;
        int n0, n;
        nvec = 0; nfail = 0; cyc = 0; ndone = 0; ndone_base = 0;
        done_cyc = 0; con_fall_cyc = -1; last_rx_cyc = 0; rd_first = 0; rd_last = 0;
        last_err = 3'd0; last_exc = 8'h00;
        con_seen = 1'b0; prev_con = 1'b0; prev_idle = 1'b0; fall_ok = 1'b0;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_func = 1'b0; cmd_slave = 8'h00;
        cmd_reg = 16'h0; cmd_cnt = 5'd0; cmd_wdata = 16'h0; rx_data = 8'h00; rx_valid = 1'b0;
        repeat (3) tick();
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_con", 32'(con), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_rd_valid", 32'(rd_word_valid), 32'd0);
        chk("rst_exc_code", 32'(exc_code), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("ready_after_rst", 32'(cmd_ready), 32'd1);

        // Read one register
        issue(1'b0, 8'h01, 16'h0000, 5'd1, 16'h0);
        wait_con_fall("rd1");
        chk_tx("rd1_tx", '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h84, 8'h0A});
        chk("rd1_con_after_idle", 32'(fall_ok), 32'd1);
        send_crc('{8'h01, 8'h03, 8'h02, 8'h12, 8'h34}, 8'h00);
        wait_done("rd1", 50);
        chk("rd1_err", 32'(last_err), 32'd0);
        chk("rd1_nwords", 32'(rdq.size()), 32'd1);
        if (rdq.size() > 0) begin
            chk("rd1_word", 32'(rdq[0]), 32'h1234);
            chk("rd1_idx", 32'(rdiq[0]), 32'd0);
        end

        // Read sixteen registers
        issue(1'b0, 8'h01, 16'h0000, 5'd16, 16'h0);
        wait_con_fall("rd16");
        f = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h10};
        c = mcrc(f);
        f.push_back(c[7:0]); f.push_back(c[15:8]);
        chk_tx("rd16_tx", f);
        f = '{8'h01, 8'h03, 8'h20};
        for (int i = 0; i < 16; i++) begin f.push_back(8'h00); f.push_back(8'(i)); end
        send_crc(f, 8'h00);
        wait_done("rd16", 50);
        chk("rd16_err", 32'(last_err), 32'd0);
        chk("rd16_nwords", 32'(rdq.size()), 32'd16);
        for (int i = 0; i < 16 && i < rdq.size(); i++) begin
            chk($sformatf("rd16_word%0d", i), 32'(rdq[i]), 32'(i));
            chk($sformatf("rd16_idx%0d", i), 32'(rdiq[i]), 32'(i));
        end
        chk("rd16_consecutive", 32'(rd_last - rd_first), 32'd15);

        // Invalid register counts
        issue(1'b0, 8'h01, 16'h0000, 5'd0, 16'h0);
        wait_done("cnt0", 20);
        chk("cnt0_err", 32'(last_err), 32'd5);
        chk("cnt0_con", 32'(con_seen), 32'd0);
        chk("cnt0_tx", 32'(txq.size()), 32'd0);
        issue(1'b0, 8'h01, 16'h0000, 5'd17, 16'h0);
        wait_done("cnt17", 20);
        chk("cnt17_err", 32'(last_err), 32'd5);
        chk("cnt17_con", 32'(con_seen), 32'd0);

        // Write single register, exact echo then bad echo
        issue(1'b1, 8'h01, 16'h0001, 5'd0, 16'h0003);
        wait_con_fall("wr");
        chk_tx("wr_tx", '{8'h01, 8'h06, 8'h00, 8'h01, 8'h00, 8'h03, 8'h98, 8'h0B});
        send_bytes(txq);
        wait_done("wr", 50);
        chk("wr_err", 32'(last_err), 32'd0);
        chk("wr_nwords", 32'(rdq.size()), 32'd0);
        issue(1'b1, 8'h01, 16'h0001, 5'd0, 16'h0003);
        wait_con_fall("wrbad");
        send_crc('{8'h01, 8'h06, 8'h00, 8'h01, 8'h00, 8'h04}, 8'h00);
        wait_done("wrbad", 50);
        chk("wrbad_err", 32'(last_err), 32'd4);

        // Corrupted CRC, then exception reply
        issue(1'b0, 8'h01, 16'h0000, 5'd1, 16'h0);
        wait_con_fall("crc");
        send_crc('{8'h01, 8'h03, 8'h02, 8'h12, 8'h34}, 8'hFF);
        wait_done("crc", 50);
        chk("crc_err", 32'(last_err), 32'd2);
        chk("crc_nwords", 32'(rdq.size()), 32'd0);
        issue(1'b0, 8'h01, 16'h0000, 5'd1, 16'h0);
        wait_con_fall("exc");
        send_bytes('{8'h01, 8'h83, 8'h02, 8'hC0, 8'hF1});
        wait_done("exc", 50);
        chk("exc_err", 32'(last_err), 32'd3);
        chk("exc_code", 32'(last_exc), 32'h02);

        // No reply, then a reply that stalls
        issue(1'b0, 8'h01, 16'h0000, 5'd1, 16'h0);
        wait_con_fall("tmo");
        wait_done("tmo", TMO + 50);
        chk("tmo_err", 32'(last_err), 32'd1);
        chk("tmo_cycles", 32'(done_cyc - con_fall_cyc), 32'(TMO));
        issue(1'b0, 8'h01, 16'h0000, 5'd1, 16'h0);
        wait_con_fall("gap");
        send_bytes('{8'h01, 8'h03, 8'h02});
        wait_done("gap", GAP + 50);
        chk("gap_err", 32'(last_err), 32'd4);
        chk("gap_cycles", 32'(done_cyc - last_rx_cyc), 32'(GAP));

        // Broadcast write
        issue(1'b1, 8'h00, 16'h0001, 5'd0, 16'h0005);
        wait_done("bcast", 200);
        chk("bcast_err", 32'(last_err), 32'd0);
        chk("bcast_tx", 32'(txq.size()), 32'd8);
        chk("bcast_done_at_fall", 32'(done_cyc - con_fall_cyc), 32'd0);

        // Reset while the fifth request byte is pending
        issue(1'b1, 8'h01, 16'h0002, 5'd0, 16'h0007);
        n = 0;
        while (txq.size() < 4 && n < 100) begin tick(); n++; end
        chk("rst_mid_reached", 32'(txq.size()), 32'd4);
        chk("rst_mid_con_before", 32'(con), 32'd1);
        n0 = ndone;
        rst_n = 1'b0;
        tick();
        chk("rst_mid_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_mid_con", 32'(con), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rst_mid_ready", 32'(cmd_ready), 32'd1);
        repeat (5) tick();
        chk("rst_mid_no_done", 32'(ndone - n0), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
